// File: rtl/float_triple_packer.sv
// Groups a valid/ready stream of floats into triples for the three-float sorter.
// Short groups are padded with +inf; one finished triple is buffered until the sorter goes idle.
module float_triple_packer #(
  parameter int              FLEN = 64,
  parameter logic [FLEN-1:0] PAD  = 64'h7FF0_0000_0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLEN-1:0]      in_data,
  input  logic                 in_last,
  output logic                 sort_valid_in,
  output logic [0:2][FLEN-1:0] sort_unsorted,
  output logic [1:0]           sort_pad,
  input  logic                 sort_busy,
  output logic [15:0]          issued_cnt
);

  typedef enum logic [1:0] {
    A0    = 2'd0,
    A1    = 2'd1,
    A2    = 2'd2,
    AFULL = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [0:2][FLEN-1:0] slot_r, slot_s;
  logic [1:0]           pad_r, pad_s;
  logic [0:2][FLEN-1:0] hold_r;
  logic [1:0]           hold_pad_r;
  logic                 hold_v_r;
  logic [15:0]          issued_cnt_r;
  logic                 accept_s;
  logic                 issue_s;
  logic                 transfer_s;

  assign in_ready      = (state_r != AFULL);
  assign accept_s      = in_valid && in_ready;
  assign issue_s       = hold_v_r && !sort_busy;
  // A finished triple may move into the hold in the same cycle the old one leaves.
  assign transfer_s    = (state_r == AFULL) && (!hold_v_r || issue_s);
  assign sort_valid_in = issue_s;
  assign sort_unsorted = hold_r;
  assign sort_pad      = hold_pad_r;
  assign issued_cnt    = issued_cnt_r;

  // Assembly next-state and slot/pad updates.
  always_comb begin
    state_s = state_r;
    slot_s  = slot_r;
    pad_s   = pad_r;
    case (state_r)
      A0: begin
        if (accept_s) begin
          slot_s[0] = in_data;
          if (in_last) begin
            slot_s[1] = PAD;
            slot_s[2] = PAD;
            pad_s     = 2'd2;
            state_s   = AFULL;
          end else begin
            state_s   = A1;
          end
        end else begin
          state_s = A0;
        end
      end
      A1: begin
        if (accept_s) begin
          slot_s[1] = in_data;
          if (in_last) begin
            slot_s[2] = PAD;
            pad_s     = 2'd1;
            state_s   = AFULL;
          end else begin
            state_s   = A2;
          end
        end else begin
          state_s = A1;
        end
      end
      A2: begin
        if (accept_s) begin
          slot_s[2] = in_data;
          pad_s     = 2'd0;
          state_s   = AFULL;
        end else begin
          state_s = A2;
        end
      end
      AFULL: begin
        if (transfer_s) begin
          state_s = A0;
        end else begin
          state_s = AFULL;
        end
      end
      default: begin
        state_s = A0;
      end
    endcase
  end

  // Assembly state and slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= A0;
      slot_r  <= '0;
      pad_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      slot_r  <= slot_s;
      pad_r   <= pad_s;
    end
  end

  // Hold register: loaded on transfer, emptied by an issue with no refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r     <= '0;
      hold_pad_r <= 2'd0;
      hold_v_r   <= 1'b0;
    end else if (transfer_s) begin
      hold_r     <= slot_r;
      hold_pad_r <= pad_r;
      hold_v_r   <= 1'b1;
    end else if (issue_s) begin
      hold_v_r   <= 1'b0;
    end
  end

  // Issue counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_cnt_r <= 16'd0;
    end else if (issue_s) begin
      issued_cnt_r <= issued_cnt_r + 16'd1;
    end
  end

endmodule
